// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with one request in flight.
// Decodes funct3, checks alignment, lane-aligns and extends load data.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [1:0]       sz_q, sz_d;
  logic             sgn_q, sgn_d;
  logic [1:0]       off_q, off_d;

  logic [1:0]       sz;
  logic             sgn;
  logic             legal;
  logic             misal;
  logic [3:0]       be;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] ext;

  always_comb begin
    sz    = req_funct3[1:0];
    sgn   = ~req_funct3[2];
    legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_store;
      default:                legal = 1'b0;
    endcase
    misal = 1'b0;
    be    = 4'b1111;
    wd    = req_wdata;
    unique case (1'b1)
      (sz == SZ_B): begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      (sz == SZ_H): begin
        misal = req_addr[0];
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wd    = {2{req_wdata[15:0]}};
      end
      default: misal = |req_addr[1:0];
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    sh  = mem_rdata >> {off_q, 3'b000};
    ext = sh;
    unique case (1'b1)
      (sz_q == SZ_B): ext = {{24{sgn_q & sh[7]}}, sh[7:0]};
      (sz_q == SZ_H): ext = {{16{sgn_q & sh[15]}}, sh[15:0]};
      default:        ext = sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rv_d    = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    sz_d    = sz_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal || misal) begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            we_d    = req_store;
            addr_d  = {req_addr[WIDTH-1:2], 2'b00};
            be_d    = be;
            wdata_d = wd;
            sz_d    = sz;
            sgn_d   = sgn;
            off_d   = req_addr[1:0];
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_RESP;
          req_d   = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : ext;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_RESP;
          req_d   = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      sz_q    <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      sz_q    <= sz_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a rule-level reference model; two instances cover TIMEOUT=4/0.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_valid0;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        mem_ack, mem_ack0;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        req_ready0, resp_valid0, resp_err0, mem_req0, mem_we0;
  logic [31:0] resp_rdata0, mem_addr0, mem_wdata0;
  logic [3:0]  mem_be0;

  int vectors = 0;
  int miscompares = 0;
  bit sel = 1'b0;

  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.WIDTH(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_err(resp_err0),
    .resp_rdata(resp_rdata0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_be(mem_be0), .mem_wdata(mem_wdata0),
    .mem_ack(mem_ack0), .mem_rdata(mem_rdata)
  );

  logic        o_ready, o_rv, o_err, o_req, o_we;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  assign o_ready = sel ? req_ready0  : req_ready;
  assign o_rv    = sel ? resp_valid0 : resp_valid;
  assign o_err   = sel ? resp_err0   : resp_err;
  assign o_rdata = sel ? resp_rdata0 : resp_rdata;
  assign o_req   = sel ? mem_req0    : mem_req;
  assign o_we    = sel ? mem_we0     : mem_we;
  assign o_addr  = sel ? mem_addr0   : mem_addr;
  assign o_be    = sel ? mem_be0     : mem_be;
  assign o_wdata = sel ? mem_wdata0  : mem_wdata;

  typedef struct {
    logic        got;
    int          lat;
    int          nreq;
    logic        err;
    logic [31:0] rdat;
    logic [31:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic        mwe;
    logic        stable;
    logic        rdy;
    logic        reqr;
  } res_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic        e_err;
    int          e_lat;
    int          e_nreq;
    logic [31:0] e_rd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } vec_t;

  // Issue one request; ack after dly WAIT cycles; observe until response.
  task automatic txn(input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int dly,
                     output res_t r);
    r.got = 0; r.lat = 0; r.nreq = 0; r.err = 0; r.rdat = '0;
    r.maddr = '0; r.mbe = '0; r.mwd = '0; r.mwe = 0;
    r.stable = 1; r.rdy = 1; r.reqr = 0;
    @(negedge clk);
    req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    if (sel) req_valid0 = 1'b1;
    else     req_valid  = 1'b1;
    for (int k = 1; k <= 40 && !r.got; k++) begin
      @(negedge clk);
      req_valid = 0; req_valid0 = 0;
      mem_ack = 0; mem_ack0 = 0;
      mem_rdata = $urandom;
      req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom); req_store = 1'($urandom);
      if (o_rv) begin
        r.got = 1; r.lat = k; r.err = o_err; r.rdat = o_rdata;
        r.rdy = o_ready; r.reqr = o_req;
      end else if (o_req) begin
        if (r.nreq == 0) begin
          r.maddr = o_addr; r.mbe = o_be;
          r.mwd = o_wdata; r.mwe = o_we;
        end else if (o_addr !== r.maddr || o_be !== r.mbe ||
                     o_wdata !== r.mwd || o_we !== r.mwe) begin
          r.stable = 0;
        end
        if (r.nreq == dly) begin
          if (sel) mem_ack0 = 1'b1;
          else     mem_ack  = 1'b1;
          mem_rdata = rd;
        end
        r.nreq++;
      end
    end
  endtask

  // Reference model built from the access rules with plain arithmetic.
  function automatic void model(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int dly,
                                input int to, output vec_t e);
    int n;
    logic legal;
    longint v;
    e.st = st; e.f3 = f3; e.a = a; e.wd = wd; e.rd = rd; e.dly = dly;
    legal = (f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    n = (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
    e.e_addr = a - (a % 4);
    e.e_be = 4'(((1 << n) - 1) << (a % 4));
    for (int i = 0; i < 4; i++) e.e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    if (!legal || (a % n) != 0) begin
      e.e_err = 1; e.e_lat = 1; e.e_nreq = 0; e.e_rd = '0;
    end else if (to != 0 && dly >= to) begin
      e.e_err = 1; e.e_lat = to + 1; e.e_nreq = to; e.e_rd = '0;
    end else begin
      e.e_err = 0; e.e_lat = dly + 2; e.e_nreq = dly + 1;
      if (st) begin
        e.e_rd = '0;
      end else begin
        v = (64'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
        if (f3 < 3'd4 && n < 4 && v >= (64'd1 << (8 * n - 1)))
          v = v - (64'd1 << (8 * n));
        e.e_rd = 32'(v);
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_we: got %b%b required 00", mem_req, mem_we);
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_be !== '0) begin
      miscompares++;
      $display("FAIL reset_mem: got %h %h %h required 0",
               mem_addr, mem_wdata, mem_be);
    end
    vectors++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_resp: got %b %b %h required 0 0 0",
               resp_valid, resp_err, resp_rdata);
    end
    vectors++;
    if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b %b required 1 1",
               req_ready, req_ready0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: ready %b req %b rv %b required 1 0 0",
               req_ready, mem_req, resp_valid);
    end
  endtask

  task automatic test_directed();
    vec_t t[15];
    res_t r;
    t[0]  = '{0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0,
              0, 2, 1, 32'hDEADBEEF, 32'h10, 4'b1111, 0};
    t[1]  = '{0, 3'b000, 32'h13, 0, 32'h80AABBCC, 0,
              0, 2, 1, 32'hFFFFFF80, 32'h10, 4'b1000, 0};
    t[2]  = '{0, 3'b100, 32'h13, 0, 32'h80AABBCC, 0,
              0, 2, 1, 32'h00000080, 32'h10, 4'b1000, 0};
    t[3]  = '{0, 3'b001, 32'h12, 0, 32'h80AABBCC, 0,
              0, 2, 1, 32'hFFFF80AA, 32'h10, 4'b1100, 0};
    t[4]  = '{0, 3'b101, 32'h12, 0, 32'h80AABBCC, 0,
              0, 2, 1, 32'h000080AA, 32'h10, 4'b1100, 0};
    t[5]  = '{0, 3'b000, 32'h10, 0, 32'h1234567F, 1,
              0, 3, 2, 32'h0000007F, 32'h10, 4'b0001, 0};
    t[6]  = '{1, 3'b000, 32'h21, 32'h12345678, 32'hCAFEF00D, 0,
              0, 2, 1, 32'h0, 32'h20, 4'b0010, 32'h78787878};
    t[7]  = '{1, 3'b001, 32'h22, 32'h12345678, 32'hCAFEF00D, 0,
              0, 2, 1, 32'h0, 32'h20, 4'b1100, 32'h56785678};
    t[8]  = '{1, 3'b010, 32'h24, 32'h12345678, 32'hCAFEF00D, 2,
              0, 4, 3, 32'h0, 32'h24, 4'b1111, 32'h12345678};
    t[9]  = '{0, 3'b010, 32'h02, 0, 32'hFFFFFFFF, 0,
              1, 1, 0, 32'h0, 32'h0, 4'b0, 0};
    t[10] = '{1, 3'b001, 32'h01, 32'h5555, 32'hFFFFFFFF, 0,
              1, 1, 0, 32'h0, 32'h0, 4'b0, 0};
    t[11] = '{0, 3'b011, 32'h10, 0, 32'hFFFFFFFF, 0,
              1, 1, 0, 32'h0, 32'h0, 4'b0, 0};
    t[12] = '{1, 3'b100, 32'h10, 32'h1, 32'hFFFFFFFF, 0,
              1, 1, 0, 32'h0, 32'h0, 4'b0, 0};
    t[13] = '{0, 3'b110, 32'h10, 0, 32'hFFFFFFFF, 0,
              1, 1, 0, 32'h0, 32'h0, 4'b0, 0};
    t[14] = '{0, 3'b001, 32'h13, 0, 32'hFFFFFFFF, 0,
              1, 1, 0, 32'h0, 32'h0, 4'b0, 0};
    sel = 1'b0;
    foreach (t[i]) begin
      txn(t[i].st, t[i].f3, t[i].a, t[i].wd, t[i].rd, t[i].dly, r);
      vectors++;
      if (r.got !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_resp: no resp_valid within budget", i);
      end
      vectors++;
      if (r.lat != t[i].e_lat || r.nreq != t[i].e_nreq) begin
        miscompares++;
        $display("FAIL dir%0d_timing: lat %0d nreq %0d required %0d %0d",
                 i, r.lat, r.nreq, t[i].e_lat, t[i].e_nreq);
      end
      vectors++;
      if (r.err !== t[i].e_err || r.rdat !== t[i].e_rd) begin
        miscompares++;
        $display("FAIL dir%0d_data: err %b rdata %h required %b %h",
                 i, r.err, r.rdat, t[i].e_err, t[i].e_rd);
      end
      vectors++;
      if (r.rdy !== 1'b0 || r.reqr !== 1'b0) begin
        miscompares++;
        $display("FAIL dir%0d_resp_state: ready %b req %b required 0 0",
                 i, r.rdy, r.reqr);
      end
      if (t[i].e_nreq > 0) begin
        vectors++;
        if (r.maddr !== t[i].e_addr || r.mbe !== t[i].e_be ||
            r.mwd !== t[i].e_wd || r.mwe !== t[i].st) begin
          miscompares++;
          $display("FAIL dir%0d_mem: %h %b %h %b required %h %b %h %b",
                   i, r.maddr, r.mbe, r.mwd, r.mwe,
                   t[i].e_addr, t[i].e_be, t[i].e_wd, t[i].st);
        end
      end
    end
  endtask

  task automatic test_timeout();
    res_t r;
    sel = 1'b0;
    txn(0, 3'b010, 32'h40, 0, 32'h11112222, 1000, r);
    vectors++;
    if (r.got !== 1'b1 || r.nreq != 4 || r.lat != 5) begin
      miscompares++;
      $display("FAIL to_expire: got %b nreq %0d lat %0d required 1 4 5",
               r.got, r.nreq, r.lat);
    end
    vectors++;
    if (r.err !== 1'b1 || r.rdat !== 32'h0 || r.reqr !== 1'b0) begin
      miscompares++;
      $display("FAIL to_expire_resp: err %b rdata %h req %b required 1 0 0",
               r.err, r.rdat, r.reqr);
    end
    txn(0, 3'b010, 32'h44, 0, 32'h33334444, 3, r);
    vectors++;
    if (r.got !== 1'b1 || r.nreq != 4 || r.err !== 1'b0 ||
        r.rdat !== 32'h33334444) begin
      miscompares++;
      $display("FAIL to_ack_last: nreq %0d err %b rdata %h required 4 0 33334444",
               r.nreq, r.err, r.rdat);
    end
  endtask

  task automatic test_no_timeout();
    res_t r;
    sel = 1'b1;
    txn(1, 3'b000, 32'h83, 32'h000000A5, 0, 3, r);
    vectors++;
    if (r.got !== 1'b1 || r.nreq != 4 || r.lat != 5 || r.err !== 1'b0) begin
      miscompares++;
      $display("FAIL nto_delay3: nreq %0d lat %0d err %b required 4 5 0",
               r.nreq, r.lat, r.err);
    end
    vectors++;
    if (r.stable !== 1'b1 || r.mbe !== 4'b1000 || r.mwd !== 32'hA5A5A5A5 ||
        r.maddr !== 32'h80 || r.mwe !== 1'b1) begin
      miscompares++;
      $display("FAIL nto_stable: st %b %h %b %h required 1 80 1000 a5a5a5a5",
               r.stable, r.maddr, r.mbe, r.mwd);
    end
    txn(0, 3'b010, 32'h88, 0, 32'h0BADF00D, 20, r);
    vectors++;
    if (r.got !== 1'b1 || r.nreq != 21 || r.err !== 1'b0 ||
        r.rdat !== 32'h0BADF00D || r.stable !== 1'b1) begin
      miscompares++;
      $display("FAIL nto_long: nreq %0d err %b rdata %h required 21 0 0badf00d",
               r.nreq, r.err, r.rdat);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    res_t r;
    bit saw_rv;
    sel = 1'b0;
    @(negedge clk);
    req_store = 0; req_funct3 = 3'b010;
    req_addr = 32'h50; req_wdata = 0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_inwait: mem_req %b required 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_async: req %b rv %b ready %b required 0 0 1",
               mem_req, resp_valid, req_ready);
    end
    saw_rv = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) saw_rv = 1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_req) saw_rv = 1;
    end
    vectors++;
    if (saw_rv !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_no_resp: stray activity %b required 0", saw_rv);
    end
    txn(0, 3'b010, 32'h30, 0, 32'h600DCAFE, 1, r);
    vectors++;
    if (r.got !== 1'b1 || r.lat != 3 || r.err !== 1'b0 ||
        r.rdat !== 32'h600DCAFE) begin
      miscompares++;
      $display("FAIL rmw_after: lat %0d err %b rdata %h required 3 0 600dcafe",
               r.lat, r.err, r.rdat);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    vec_t e;
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd, rd;
    int dly;
    for (int i = 0; i < 80; i++) begin
      sel = ($urandom_range(0, 3) == 0);
      st = 1'($urandom);
      f3 = 3'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom;
      dly = $urandom_range(0, 5);
      model(st, f3, a, wd, rd, dly, sel ? 0 : 4, e);
      txn(st, f3, a, wd, rd, dly, r);
      vectors++;
      if (r.got !== 1'b1 || r.lat != e.e_lat || r.nreq != e.e_nreq) begin
        miscompares++;
        $display("FAIL rnd%0d_timing: got %b lat %0d nreq %0d required 1 %0d %0d",
                 i, r.got, r.lat, r.nreq, e.e_lat, e.e_nreq);
      end
      vectors++;
      if (r.err !== e.e_err || r.rdat !== e.e_rd) begin
        miscompares++;
        $display("FAIL rnd%0d_resp: st %b f3 %b a %h err %b rdata %h required %b %h",
                 i, st, f3, a, r.err, r.rdat, e.e_err, e.e_rd);
      end
      if (e.e_nreq > 0) begin
        vectors++;
        if (r.maddr !== e.e_addr || r.mbe !== e.e_be || r.mwd !== e.e_wd ||
            r.mwe !== st || r.stable !== 1'b1) begin
          miscompares++;
          $display("FAIL rnd%0d_mem: %h %b %h %b %b required %h %b %h %b 1",
                   i, r.maddr, r.mbe, r.mwd, r.mwe, r.stable,
                   e.e_addr, e.e_be, e.e_wd, st);
        end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 0; req_valid0 = 0;
    req_store = 0; req_funct3 = 3'b010;
    req_addr = '0; req_wdata = '0;
    mem_ack = 0; mem_ack0 = 0; mem_rdata = '0;
    test_reset();
    test_directed();
    test_timeout();
    test_no_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
